// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for a single-port word-wide data memory.
// Sub-word stores are done as read-modify-write; one transaction in flight at a time.
module dm_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    output logic              m0_ready,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    output logic              m1_ready,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              id;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-3:0] word;
    logic [31:0]       wdata;
    logic [31:0]       cap;
    logic [31:0]       rdata_q0, rdata_q1;
    logic              grant0, grant1;
    logic              accept0, accept1;
    logic              partial;

    // m1 wins a tie only under round-robin when m0 was granted last
    assign grant0 = m0_req & (~m1_req | ~FAIR | last_grant);
    assign grant1 = m1_req & (~m0_req | (FAIR & ~last_grant));

    assign m0_ready = (state == IDLE) & ~reset & grant0;
    assign m1_ready = (state == IDLE) & ~reset & grant1;
    assign accept0  = m0_req & m0_ready;
    assign accept1  = m1_req & m1_ready;
    assign partial  = we & (be != 4'hF) & (be != 4'h0);
    assign busy     = (state != IDLE);

    assign m0_ack   = (state == RESP) & ~reset & ~id;
    assign m1_ack   = (state == RESP) & ~reset & id;
    // load data is presented directly from the capture register during the ack cycle
    assign m0_rdata = (m0_ack & ~we) ? cap : rdata_q0;
    assign m1_rdata = (m1_ack & ~we) ? cap : rdata_q1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            we         <= 1'b0;
            be         <= 4'h0;
            word       <= '0;
            wdata      <= 32'h0;
            cap        <= 32'h0;
            rdata_q0   <= 32'h0;
            rdata_q1   <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept0 | accept1) begin
                        id         <= accept1;
                        last_grant <= accept1;
                        we         <= accept1 ? m1_we    : m0_we;
                        be         <= accept1 ? m1_be    : m0_be;
                        word       <= accept1 ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
                        wdata      <= accept1 ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS: begin
                    if (~we | partial) cap <= mem_rdata;
                end
                RESP: begin
                    if (~we) begin
                        if (id) rdata_q1 <= cap;
                        else    rdata_q0 <= cap;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        case (state)
            IDLE: begin
                if (accept0 | accept1) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_addr  = {word, 2'b00};
                state_nxt = partial ? MERGE : RESP;
                if (we && be == 4'hF) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata;
                end
            end
            MERGE: begin
                mem_addr  = {word, 2'b00};
                mem_we    = 1'b1;
                for (int i = 0; i < 4; i++)
                    mem_wdata[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cap[8*i +: 8];
                state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // reset aborts: no memory traffic during the reset cycle
        if (reset) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = 32'h0;
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a round-robin instance and a fixed-priority one
// share stimulus and a behavioural word memory.
module tb_dm_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready, m0_ack, m1_ack, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        f_m0_ready, f_m1_ready, f_m0_ack, f_m1_ack, f_mem_we, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [31:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr[7:2]];
    assign f_mem_rdata = mem[f_mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    dm_port_arbiter #(.ADDR_W(32), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_ready(m0_ready), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_ready(m1_ready), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy));

    dm_port_arbiter #(.ADDR_W(32), .FAIR(1'b0)) dut_fix (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_ready(f_m0_ready), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_ready(f_m1_ready), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
        .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .busy(f_busy));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8'h10 >> 2] = 32'h12345678;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h10; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h10; m1_wdata = 32'h0;
        tick; tick;
        // reset state, with requests present
        check("rst_ready0", m0_ready, 0);
        check("rst_ready1", m1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_ack0", m0_ack, 0);
        m1_req = 1'b0;
        reset = 1'b0;
        #1;

        // 1: m0 load 0x10
        check("t1_ready0", m0_ready, 1);
        tick; m0_req = 1'b0; #1;
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_busy", busy, 1);
        check("t1_ack_early", m0_ack, 0);
        tick;
        check("t1_ack", m0_ack, 1);
        check("t1_rdata", m0_rdata, 32'h12345678);
        tick;
        check("t1_ack_off", m0_ack, 0);
        check("t1_rdata_hold", m0_rdata, 32'h12345678);
        check("t1_idle", busy, 0);

        // 2: m1 full-word store 0x20, then m0 reads it back
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF; #1;
        check("t2_ready1", m1_ready, 1);
        check("t2_we_T", mem_we, 0);
        tick; m1_req = 1'b0; m1_wdata = 32'h0; #1;
        check("t2_we", mem_we, 1);
        check("t2_wdata", mem_wdata, 32'hDEADBEEF);
        check("t2_addr", mem_addr, 32'h20);
        tick;
        check("t2_we_off", mem_we, 0);
        check("t2_ack", m1_ack, 1);
        tick;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; #1;
        check("t2_rd_ready", m0_ready, 1);
        tick; m0_req = 1'b0; tick;
        check("t2_rd_ack", m0_ack, 1);
        check("t2_rd_data", m0_rdata, 32'hDEADBEEF);
        tick;

        // 3: partial store be=0011 on 0x30
        mem[8'h30 >> 2] = 32'h11223344;
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0011; m0_addr = 32'h30; m0_wdata = 32'h0000ABCD; #1;
        check("t3_ready0", m0_ready, 1);
        tick; m0_req = 1'b0; m0_be = 4'hF; m0_wdata = 32'hFFFFFFFF; #1;
        check("t3_we_T1", mem_we, 0);
        check("t3_addr_T1", mem_addr, 32'h30);
        tick;
        check("t3_we_T2", mem_we, 1);
        check("t3_wdata", mem_wdata, 32'h1122ABCD);
        check("t3_ack_T2", m0_ack, 0);
        tick;
        check("t3_ack", m0_ack, 1);
        check("t3_we_T3", mem_we, 0);
        check("t3_rdata_kept", m0_rdata, 32'hDEADBEEF);
        tick;
        check("t3_mem", mem[8'h30 >> 2], 32'h1122ABCD);

        // 5: reset during MERGE of the same partial store
        mem[8'h30 >> 2] = 32'h11223344;
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0011; m0_addr = 32'h30; m0_wdata = 32'h0000ABCD; #1;
        tick; m0_req = 1'b0; tick;
        reset = 1'b1; #1;
        check("t5_we", mem_we, 0);
        check("t5_ack", m0_ack, 0);
        tick; reset = 1'b0; #1;
        check("t5_idle", busy, 0);
        check("t5_ack_after", m0_ack, 0);
        tick;
        check("t5_ack_later", m0_ack, 0);
        check("t5_mem", mem[8'h30 >> 2], 32'h11223344);

        // 6: empty store on 0x40
        mem[8'h40 >> 2] = 32'hCAFEF00D;
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h0; m1_addr = 32'h40; m1_wdata = 32'h55555555; #1;
        check("t6_ready1", m1_ready, 1);
        check("t6_we_T", mem_we, 0);
        tick; m1_req = 1'b0; #1;
        check("t6_we_T1", mem_we, 0);
        tick;
        check("t6_we_T2", mem_we, 0);
        check("t6_ack", m1_ack, 1);
        tick;
        check("t6_mem", mem[8'h40 >> 2], 32'hCAFEF00D);

        // 4: both requesting loads from reset; round-robin vs fixed priority
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        tick; reset = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_rr_ready0_%0d", k), m0_ready, (k % 2 == 0));
            check($sformatf("t4_rr_ready1_%0d", k), m1_ready, (k % 2 == 1));
            check($sformatf("t4_fix_ready0_%0d", k), f_m0_ready, 1);
            check($sformatf("t4_fix_ready1_%0d", k), f_m1_ready, 0);
            tick; tick;
            check($sformatf("t4_rr_ack1_%0d", k), m1_ack, (k % 2 == 1));
            check($sformatf("t4_fix_ack0_%0d", k), f_m0_ack, 1);
            tick; #1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
